// File: rtl/link_out_piso_credit.sv
// Serialises one wide core word into RATIO narrow beats toward a credit-based link.
// Each beat uses one credit. The link returns a credit as a one-cycle pulse on credit_i.
module link_out_piso_credit #(
  parameter int CHANNELS    = 2,
  parameter int CH_WIDTH    = 8,
  parameter int RATIO       = 4,
  parameter int MAX_CREDITS = 8,
  localparam int BW  = CHANNELS * CH_WIDTH,
  localparam int W   = BW * RATIO,
  localparam int CW  = $clog2(MAX_CREDITS + 1),
  localparam int BCW = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  input  logic [W-1:0]  data_i,
  output logic          ready_o,
  output logic          valid_o,
  output logic [BW-1:0] data_o,
  input  logic          credit_i,
  output logic [CW-1:0] credits_o,
  output logic          overflow_o
);

  logic [W-1:0]   r_word;
  logic           r_full;
  logic [BCW-1:0] r_beat;
  logic [CW-1:0]  r_credits;
  logic           r_overflow;

  logic w_send;
  logic w_last;
  logic w_accept;

  assign w_send   = r_full & (r_credits != '0);
  assign w_last   = (r_beat == BCW'(RATIO - 1));
  // A new word can land in the same cycle the last beat of the previous one leaves.
  assign ready_o  = ~rst & (~r_full | (w_send & w_last));
  assign w_accept = valid_i & ready_o;

  assign valid_o    = w_send;
  assign data_o     = w_send ? r_word[r_beat * BW +: BW] : '0;
  assign credits_o  = r_credits;
  assign overflow_o = r_overflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word     <= '0;
      r_full     <= 1'b0;
      r_beat     <= '0;
      r_credits  <= CW'(MAX_CREDITS);
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_word <= data_i;
        r_full <= 1'b1;
        r_beat <= '0;
      end else if (w_send) begin
        if (w_last) begin
          r_full <= 1'b0;
          r_beat <= '0;
        end else begin
          r_beat <= r_beat + 1'b1;
        end
      end

      // A returned credit and a sent beat in the same cycle cancel out.
      case ({credit_i, w_send})
        2'b10: begin
          if (r_credits == CW'(MAX_CREDITS)) begin
            r_overflow <= 1'b1;
          end else begin
            r_credits <= r_credits + 1'b1;
          end
        end
        2'b01:   r_credits <= r_credits - 1'b1;
        default: r_credits <= r_credits;
      endcase
    end
  end

endmodule

// File: tb/tb_link_out_piso_credit.sv
// Directed bench for link_out_piso_credit at default parameters (2x8-bit lanes, 4 beats, 8 credits).
module tb_link_out_piso_credit;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [63:0] data_i;
  logic        ready_o;
  logic        valid_o;
  logic [15:0] data_o;
  logic        credit_i;
  logic [3:0]  credits_o;
  logic        overflow_o;

  int checks   = 0;
  int failures = 0;

  link_out_piso_credit dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .data_i     (data_i),
    .ready_o    (ready_o),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .credit_i   (credit_i),
    .credits_o  (credits_o),
    .overflow_o (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are checked 1 unit later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [15:0] exp30 [4] = '{16'h0100, 16'h0302, 16'h0504, 16'h0706};
  logic [15:0] exp31 [8] = '{16'h1110, 16'h1312, 16'h1514, 16'h1716,
                             16'h2120, 16'h2322, 16'h2524, 16'h2726};

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; valid_i = 1'b0; data_i = '0; credit_i = 1'b0;
    step(); step();
    #1;
    check("rst_ready", ready_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_credits", credits_o, 8);
    check("rst_ovf", overflow_o, 0);

    // valid_i and credit_i must be ignored while reset is high
    step();
    valid_i = 1'b1; data_i = 64'hAAAA_AAAA_AAAA_AAAA; credit_i = 1'b1;
    #1 check("rst_ready_busy", ready_o, 0);

    step();
    rst = 1'b0; valid_i = 1'b0; credit_i = 1'b0;
    #1;
    check("post_rst_ready", ready_o, 1);
    check("post_rst_valid", valid_o, 0);
    check("post_rst_credits", credits_o, 8);
    check("post_rst_ovf", overflow_o, 0);

    // single word, 4 beats, latency 1
    step();
    valid_i = 1'b1; data_i = 64'h0706_0504_0302_0100;
    #1 check("w0_ready", ready_o, 1);
    for (int b = 0; b < 4; b++) begin
      step();
      valid_i = 1'b0;
      #1;
      check($sformatf("w0_valid%0d", b), valid_o, 1);
      check($sformatf("w0_data%0d", b), data_o, exp30[b]);
      check($sformatf("w0_credits%0d", b), credits_o, 64'(8 - b));
      check($sformatf("w0_ready%0d", b), ready_o, (b == 3) ? 1 : 0);
    end
    step();
    #1;
    check("w0_done_valid", valid_o, 0);
    check("w0_done_credits", credits_o, 4);

    for (int i = 0; i < 4; i++) begin
      step();
      credit_i = 1'b1;
    end

    // two back-to-back words, third word queued behind them
    step();
    credit_i = 1'b0; valid_i = 1'b1; data_i = 64'h1716_1514_1312_1110;
    #1;
    check("refill_credits", credits_o, 8);
    check("w1_ready", ready_o, 1);
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 0) data_i = 64'h2726_2524_2322_2120;
      if (k == 4) data_i = 64'h3736_3534_3332_3130;
      #1;
      check($sformatf("b2b_valid%0d", k), valid_o, 1);
      check($sformatf("b2b_data%0d", k), data_o, exp31[k]);
      check($sformatf("b2b_credits%0d", k), credits_o, 64'(8 - k));
      check($sformatf("b2b_ready%0d", k), ready_o, (k == 3 || k == 7) ? 1 : 0);
    end

    // stalled on zero credits; the held word must not be overwritten
    step();
    data_i = 64'hDEAD_BEEF_DEAD_BEEF;
    #1;
    check("stall_valid", valid_o, 0);
    check("stall_data", data_o, 0);
    check("stall_ready", ready_o, 0);
    check("stall_credits", credits_o, 0);
    step();
    credit_i = 1'b1;
    #1 check("stall_valid2", valid_o, 0);
    step();
    credit_i = 1'b0;
    #1;
    check("one_credit_valid", valid_o, 1);
    check("one_credit_data", data_o, 16'h3130);
    check("one_credit_credits", credits_o, 1);
    step();
    #1;
    check("one_credit_after_valid", valid_o, 0);
    check("one_credit_after_data", data_o, 0);
    check("one_credit_after_credits", credits_o, 0);
    check("one_credit_after_ready", ready_o, 0);

    // continuous credits drain the held word: each send is matched by a credit
    step();
    credit_i = 1'b1; valid_i = 1'b0;
    #1 check("drain_c0_valid", valid_o, 0);
    step();
    #1;
    check("drain_beat1_data", data_o, 16'h3332);
    check("drain_beat1_credits", credits_o, 1);
    step();
    #1;
    check("drain_beat2_data", data_o, 16'h3534);
    check("drain_beat2_credits", credits_o, 1);
    step();
    #1;
    check("drain_beat3_data", data_o, 16'h3736);
    check("drain_beat3_ready", ready_o, 1);
    step();
    #1;
    check("drain_idle_valid", valid_o, 0);
    check("drain_idle_credits", credits_o, 1);
    step();
    #1 check("credit_up2", credits_o, 2);

    // credit coincident with a send at credits 3
    step();
    credit_i = 1'b0; valid_i = 1'b1; data_i = 64'h4746_4544_4342_4140;
    #1;
    check("w4_credits", credits_o, 3);
    check("w4_ready", ready_o, 1);
    step();
    valid_i = 1'b0; credit_i = 1'b1;
    #1;
    check("w4_data0", data_o, 16'h4140);
    check("w4_credits0", credits_o, 3);
    step();
    credit_i = 1'b0;
    #1;
    check("coincident_credits", credits_o, 3);
    check("w4_data1", data_o, 16'h4342);
    step();
    #1 check("w4_credits2", credits_o, 2);
    step();
    #1;
    check("w4_data3", data_o, 16'h4746);
    check("w4_credits3", credits_o, 1);
    step();
    #1 check("w4_done_credits", credits_o, 0);

    // refill to the cap, then one credit too many
    for (int i = 0; i < 8; i++) begin
      step();
      credit_i = 1'b1;
    end
    step();
    #1;
    check("cap_credits", credits_o, 8);
    check("cap_ovf_before", overflow_o, 0);
    step();
    credit_i = 1'b0;
    #1;
    check("sat_credits", credits_o, 8);
    check("sat_ovf", overflow_o, 1);

    // reset mid-word
    step();
    valid_i = 1'b1; data_i = 64'h5756_5554_5352_5150;
    #1;
    check("ovf_sticky", overflow_o, 1);
    check("w5_ready", ready_o, 1);
    step();
    valid_i = 1'b0;
    #1 check("w5_data0", data_o, 16'h5150);
    step();
    #1 check("w5_data1", data_o, 16'h5352);
    step();
    rst = 1'b1; valid_i = 1'b1; data_i = 64'h6766_6564_6362_6160; credit_i = 1'b1;
    #1 check("midrst_ready", ready_o, 0);
    step();
    rst = 1'b0; credit_i = 1'b0;
    #1;
    check("after_rst_valid", valid_o, 0);
    check("after_rst_data", data_o, 0);
    check("after_rst_credits", credits_o, 8);
    check("after_rst_ovf", overflow_o, 0);
    check("after_rst_ready", ready_o, 1);
    step();
    valid_i = 1'b0;
    #1;
    check("w6_valid", valid_o, 1);
    check("w6_data0", data_o, 16'h6160);
    check("w6_credits", credits_o, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/link_out_piso_credit.md
LINK_OUT_PISO_CREDIT -- requirements
Module: link_out_piso_credit

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, meaning number of parallel output lanes.
REQ-002 SHALL have parameter CH_WIDTH, default 8, meaning bits per lane per beat.
REQ-003 SHALL have parameter RATIO, default 4, meaning beats per input word (RATIO >= 1); derived W = CHANNELS*CH_WIDTH*RATIO.
REQ-004 SHALL have parameter MAX_CREDITS, default 8, meaning credit counter capacity and reset value; derived CW = clog2(MAX_CREDITS+1).
REQ-005 SHALL have ports: clk  in  1  clock, all logic on rising edge.
REQ-006 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports: valid_i  in  1  core word valid.
REQ-008 SHALL have ports: data_i  in  W  core word.
REQ-009 SHALL have ports: ready_o  out  1  word accepted when valid_i & ready_o.
REQ-010 SHALL have ports: valid_o  out  1  beat valid toward link.
REQ-011 SHALL have ports: data_o  out  CHANNELS*CH_WIDTH  current beat; lane c is bits [c*CH_WIDTH +: CH_WIDTH].
REQ-012 SHALL have ports: credit_i  in  1  one-cycle pulse returning one credit.
REQ-013 SHALL have ports: credits_o  out  CW  current credit count.
REQ-014 SHALL have ports: overflow_o  out  1  sticky credit-overflow error flag.

Function
REQ-015 SHALL hold one word in a register with a full flag and beat counter beat (0..RATIO-1).
REQ-016 SHALL define send = full & (credits != 0); valid_o = send, combinational from registers only.
REQ-017 SHALL drive data_o = word bits [beat*CHANNELS*CH_WIDTH +: CHANNELS*CH_WIDTH] when send, else all zeros.
REQ-018 SHALL drive ready_o = ~rst & (~full | (send & beat == RATIO-1)), permitting zero-bubble back-to-back words.
REQ-019 SHALL on accept load data_i, set full, set beat = 0; first beat valid the following cycle (latency 1).
REQ-020 SHALL on send with beat < RATIO-1 increment beat; on send with beat == RATIO-1 set beat = 0 and clear full unless an accept occurs the same cycle.
REQ-021 SHALL, when full & credits == 0, hold word and beat unchanged with valid_o = 0 (stall, no beat lost or repeated).
REQ-022 SHALL update credits: +1 on credit_i, -1 on send, unchanged when both occur in the same cycle.
REQ-023 SHALL saturate credits at MAX_CREDITS when credit_i arrives without send at full count, and set overflow_o = 1 until reset.
REQ-024 SHALL never decrement credits below 0 (send is impossible at 0).
REQ-025 SHALL with RATIO = 1 emit each word as a single beat, ready_o high every cycle a beat is sent.
REQ-026 SHALL ignore data_i when valid_i & ~ready_o; the held word SHALL not change.

Reset
REQ-027 SHALL on rst set full = 0, beat = 0, credits = MAX_CREDITS, overflow_o = 0, discarding any partially sent word.
REQ-028 SHALL hold valid_o = 0, data_o = 0, ready_o = 0 while rst is high; ready_o = 1 the first cycle after rst falls.
REQ-029 SHALL ignore credit_i and valid_i in a cycle where rst is high.

Verification (defaults: CHANNELS=2, CH_WIDTH=8, RATIO=4, MAX_CREDITS=8)
REQ-030 SHALL cover: accept 0x0706050403020100 at edge t -> valid_o high cycles t+1..t+4, data_o 0x0100, 0x0302, 0x0504, 0x0706; credits_o 8->4; ready_o high in cycle t+4.
REQ-031 SHALL cover: valid_i held high with two words -> 8 contiguous valid_o beats, no bubble, credits_o ends at 0, ready_o low afterwards.
REQ-032 SHALL cover: third word with credits 0 -> valid_o low, data_o 0, beat held; single credit_i pulse -> exactly one beat (first slice) next cycle, credits_o back to 0.
REQ-033 SHALL cover: credit_i coincident with send at credits 3 -> credits_o stays 3.
REQ-034 SHALL cover: credit_i at credits 8 with no send -> credits_o stays 8, overflow_o = 1 and remains 1 until rst.
REQ-035 SHALL cover: rst asserted after beat 1 of a word -> next cycle valid_o 0, credits_o 8, overflow_o 0; after rst falls ready_o 1 and new word starts at beat 0.
